seq_restoring_divider: RTL and testbench

Iterative unsigned restoring divider: one quotient bit per clock, W-bit dividend and divisor, start/done handshake. It is the inverse-direction companion of the team's carry-lookahead adder datapath. Each trial subtraction is built as addition of the inverted divisor with carry-in 1 through a `carry_lookahead_unit` instance, and borrow is taken as the inverted final carry. It sits beside the adder in the arithmetic unit and serves any block needing quotient/remainder without a combinational array.

---
 rtl/seq_restoring_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, trial subtract via CLA
// One quotient bit per clock; the first bit is resolved on the accepting edge.

module carry_lookahead_unit #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  localparam int L = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] p0;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic [N:0]   c;

  // Kogge-Stone prefix: after the loop gg/pp hold group generate/propagate over [i:0]
  always_comb begin
    p0 = a_i ^ b_i;
    gg = a_i & b_i;
    pp = p0;
    for (int l = 0; l < L; l++) begin
      gg = gg | (pp & (gg << (1 << l)));
      pp = pp & ((pp << (1 << l)) | ~({N{1'b1}} << (1 << l)));
    end
    c      = {gg | (pp & {N{cin_i}}), cin_i};
    sum_o  = p0 ^ c[N-1:0];
    cout_o = c[N];
  end
endmodule

module seq_restoring_divider #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic         div_by_zero_o
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   remo_q, remo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic [W-1:0]   dvs_sel;
  logic [W-1:0]   q_sel;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   q_step;
  logic           no_borrow;
  logic           unused_trial_msb;

  // In IDLE the datapath works straight off the inputs so the accept edge yields the first bit
  always_comb begin
    if (state_q == IDLE) begin
      shifted = {{W{1'b0}}, dividend_i[W-1]};
      dvs_sel = divisor_i;
      q_sel   = dividend_i;
    end else begin
      shifted = {rem_q, q_q[W-1]};
      dvs_sel = dvs_q;
      q_sel   = q_q;
    end
  end

  carry_lookahead_unit #(.N(W + 1)) u_cla (
    .a_i   (shifted),
    .b_i   (~{1'b0, dvs_sel}),
    .cin_i (1'b1),
    .sum_o (trial),
    .cout_o(no_borrow)
  );

  assign rem_step         = no_borrow ? trial[W-1:0] : shifted[W-1:0];
  assign q_step           = {q_sel[W-2:0], no_borrow};
  assign unused_trial_msb = trial[W];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quot_d  = '1;
            remo_d  = dividend_i;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvs_d   = divisor_i;
            rem_d   = rem_step;
            q_d     = q_step;
            cnt_d   = CW'(W - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_step;
          remo_d  = rem_step;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quot_q;
  assign remainder_o   = remo_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and sweep checks for seq_restoring_divider
// Drives an 8-bit and a 4-bit instance from a shared clock.

module tb_seq_restoring_divider;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0, dvs8 = '0, q8, r8;
  logic       busy8, done8, z8;
  logic       start4 = 1'b0;
  logic [3:0] dvd4 = '0, dvs4 = '0, q4, r4;
  logic       busy4, done4, z4;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] pq = '0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.W(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .dividend_i(dvd8), .divisor_i(dvs8),
    .busy_o(busy8), .done_o(done8), .quotient_o(q8), .remainder_o(r8), .div_by_zero_o(z8)
  );

  seq_restoring_divider #(.W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .dividend_i(dvd4), .divisor_i(dvs4),
    .busy_o(busy4), .done_o(done4), .quotient_o(q4), .remainder_o(r4), .div_by_zero_o(z4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic ez, input string nm);
    int lat;
    int busyc;
    @(negedge clk);
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; busyc = 0;
    if (b != 0) chk({nm, " held_q"}, q8, pq);
    while (!done8 && lat < 40) begin
      busyc += int'(busy8);
      @(posedge clk); #1;
      lat++;
    end
    busyc += int'(busy8);
    chk({nm, " latency"}, lat, (b == 0) ? 1 : 8);
    chk({nm, " busy_cycles"}, busyc, lat);
    chk({nm, " quotient"}, q8, eq);
    chk({nm, " remainder"}, r8, er);
    chk({nm, " div_by_zero"}, z8, ez);
    @(posedge clk); #1;
    chk({nm, " busy_after"}, busy8, 1'b0);
    chk({nm, " done_after"}, done8, 1'b0);
    chk({nm, " q_hold"}, q8, eq);
    pq = eq;
  endtask

  task automatic div4(input logic [3:0] a, input logic [3:0] b);
    int lat;
    lat = 1;
    @(negedge clk);
    start4 = 1'b1; dvd4 = a; dvs4 = b;
    @(posedge clk); #1;
    start4 = 1'b0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w4 latency", lat, (b == 0) ? 1 : 4);
    if (b == 0) begin
      chk("w4 dbz result", {q4, r4, 3'b000, z4}, {4'hF, a, 4'h1});
    end else begin
      chk("w4 invariant", (int'(q4) * int'(b) + int'(r4) == int'(a)) && (r4 < b) && !z4, 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int dones;
    logic [7:0] ra, rb;

    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    vecs[3]  = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1};
    vecs[4]  = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0};
    vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vecs[7]  = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0};
    vecs[8]  = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0};
    vecs[9]  = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
    vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1};
    vecs[11] = '{8'd200, 8'd13,  8'd15,  8'd5,  1'b0};
    vecs[12] = '{8'd255, 8'd2,   8'd127, 8'd1,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy8, 1'b0);
    chk("reset done", done8, 1'b0);
    chk("reset quotient", q8, 8'd0);
    chk("reset remainder", r8, 8'd0);
    chk("reset dbz", z8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      div8(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));

    // start held high through the whole operation with new operands
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(posedge clk); #1;
    dvd8 = 8'd50; dvs8 = 8'd5;
    lat = 1; dones = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold first latency", lat, 8);
    chk("hold first quotient", q8, 8'd14);
    chk("hold first remainder", r8, 8'd2);
    @(posedge clk); #1;
    chk("hold idle done", done8, 1'b0);
    chk("hold idle busy", busy8, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("hold second accepted", busy8, 1'b1);
    lat = 1;
    while (lat < 12) begin
      dones += int'(done8);
      if (done8) begin
        chk("hold second latency", lat, 8);
        chk("hold second quotient", q8, 8'd10);
        chk("hold second remainder", r8, 8'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("hold second single done", dones, 1);
    chk("hold second idle", busy8, 1'b0);
    pq = 8'd10;

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd255; dvs8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy8, 1'b0);
    chk("midreset done", done8, 1'b0);
    chk("midreset quotient", q8, 8'd0);
    chk("midreset remainder", r8, 8'd0);
    chk("midreset dbz", z8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      dones += int'(done8);
    end
    chk("midreset no done", dones, 0);
    pq = 8'd0;
    div8(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, "post_reset");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        div4(4'(a), 4'(b));

    for (int k = 0; k < 2000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rb == 0) div8(ra, rb, 8'd255, ra, 1'b1, "rand_dbz");
      else         div8(ra, rb, ra / rb, ra % rb, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
